axi_w_downsizer: RTL and testbench
==================================

# axi_w_downsizer

Parametrised W-channel data-width downsizer: serialises each wide slave-side write beat into one or more narrow master-side beats, driven by per-burst commands queued from the AW path. Supports an arbitrary power-of-two width ratio, narrow and unaligned transfers, and FIXED/INCR bursts. It regenerates `w_last` and flags a mismatched upstream `w_last`. It sits on the W channel of the next-generation width converter, beside the AW splitter that issues its commands.

## Interface
- `SlvDataWidth`, 128: wide (slave-side) data width in bits.
- `MstDataWidth`, 32: narrow (master-side) data width in bits. Ratio `SlvDataWidth/MstDataWidth` is a power of two, ≥2.
- `UserWidth`, 1: W user width.
- `CmdDepth`, 4: command FIFO depth, ≥1.
- Derived: `SlvOff=log2(SlvDataWidth/8)`, `MstOff=log2(MstDataWidth/8)`.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `cmd_valid_i`, `cmd_ready_o` in/out 1: command handshake.
- `cmd_offset_i` in SlvOff: start address bits `[SlvOff-1:0]`.
- `cmd_size_i` in 3: AxSIZE, ≤SlvOff.
- `cmd_len_i` in 8: slave burst length −1.
- `cmd_burst_i` in 2: FIXED or INCR only.
- `slv_w_data_i`, `slv_w_strb_i`, `slv_w_user_i`, `slv_w_last_i`, `slv_w_valid_i` in: wide W beat.
- `slv_w_ready_o` out 1: wide W ready.
- `mst_w_data_o`, `mst_w_strb_o`, `mst_w_user_o`, `mst_w_last_o`, `mst_w_valid_o` out: narrow W beat.
- `mst_w_ready_i` in 1: narrow W ready.
- `last_err_o` out 1: one-cycle pulse on `slv_w_last` mismatch.

## Operation
- FSM with two states: IDLE and BUSY. Registers: `addr` (SlvOff bits), `size`, `burst`, `beats_left` (8 bits), `lane` (SlvOff−MstOff bits).
- IDLE with FIFO non-empty: pop at the clock edge, load `addr=offset`, `beats_left=len`, `lane=offset[SlvOff-1:MstOff]`, then go to BUSY.
- Per slave beat:
  - `aligned = addr & ~(2^size−1)`.
  - `end_lane = (aligned + 2^size − 1)[SlvOff-1:MstOff]`.
  - Emit lanes `lane..end_lane` in order.
- `mst_w_data_o = slv_w_data_i[lane*MstDataWidth +: MstDataWidth]`. Strobe is sliced the same way; user is copied.
- `mst_w_valid_o = BUSY & slv_w_valid_i`, combinational.
- `slv_w_ready_o = BUSY & mst_w_ready_i & (lane==end_lane)`: the wide beat is consumed only on its final sub-beat.
- On a sub-beat handshake that is not final: `lane++`.
- On the final sub-beat handshake:
  - INCR: `addr = aligned + 2^size`, truncated to SlvOff bits, so it wraps within the wide word.
  - FIXED: `addr` unchanged.
  - `lane` reloads from the new `addr`.
  - `beats_left--`.
- `mst_w_last_o = (beats_left==0) & (lane==end_lane)`. `slv_w_last_i` is never forwarded.
- `last_err_o` pulses on a slave-beat consumption where `slv_w_last_i != (beats_left==0)`. The burst continues on the command count.
- End of burst (last sub-beat handshake):
  - FIFO non-empty: pop and load the next command at the same edge, stay BUSY.
  - Otherwise go to IDLE.
- FIFO: push when `cmd_valid_i & cmd_ready_o`, with `cmd_ready_o = ~full`. A push and pop in the same cycle are both allowed. A push into a full FIFO is never accepted, even with a simultaneous pop.
- WRAP bursts or `cmd_size_i>SlvOff` are illegal; simulation assertion only.

## Timing
- Reset values: FIFO empty, state IDLE, `mst_w_valid_o=0`, `slv_w_ready_o=0`, `last_err_o=0`, `cmd_ready_o=1` from the first cycle after reset.
- While `rst_i=1`, all handshake outputs are 0.
- Reset mid-burst: the in-flight burst and all queued commands are discarded. No further sub-beats are emitted.
- Command accepted at edge k into an empty FIFO: loaded at edge k+1. First `mst_w_valid_o` is in cycle k+1 (after edge k+1).
- Data path is zero latency, combinational slv→mst.
- Bursts run back to back with no bubble.
- Sustained throughput: one narrow beat per cycle.
- While `mst_w_valid_o & ~mst_w_ready_i`, outputs stay stable, given the AXI-stable `slv_w_*` inputs.

## Structure
- Shared package `axi_pkg`:
  - burst and size typedefs and constants (`BURST_FIXED`, `BURST_INCR`);
  - `aligned_addr(addr,size)` and lane-computation functions.
- Sub-module `axi_dw_cmd_fifo`: parametrised depth, synchronous active-high reset, registered output (no fall-through), packed `{offset,size,len,burst}` entries.
- FSM, counters and lane mux live in the top module.

## Test plan
All scenarios use 128→32 bits (SlvOff=4, MstOff=2).
1. INCR, offset 0, size 4, len 0; data `0x33333333_22222222_11111111_00000000`, strb `0xFFFF` → 4 mst beats `0x0`, `0x11111111`, `0x22222222`, `0x33333333`, strb `0xF` each. Last only on the 4th; `slv_w_ready_o` only on the 4th.
2. INCR, offset 4, size 2, len 2 → 3 mst beats from lanes 1, 2, 3, last on the 3rd. Each slave beat is consumed with its single mst beat.
3. INCR, offset 6, size 3, len 1 → beat0 emits lane 1 only; beat1 (addr 8) emits lanes 2, 3. Total 3 mst beats.
4. FIXED, offset 8, size 2, len 3 → 4 mst beats, all lane 2, last on the 4th.
5. Two commands pre-queued (sizes 4/len 0 and 2/len 1); `mst_w_ready_i` pattern 1,0,1,0… → outputs stable on stalls. No bubble between bursts when ready is held high. FIFO full at CmdDepth: `cmd_ready_o=0`.
6. Len 1 burst with `slv_w_last_i=1` on beat 0 → `last_err_o` pulses 1 cycle and `mst_w_last_o` still appears only on beat 1. Then `rst_i` high mid-burst → next cycle `mst_w_valid_o=0`, FIFO empty.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI helpers for the width converter: burst/size encodings and the
// byte-address arithmetic used to locate narrow lanes inside a wide beat.
package axi_pkg;

    // Wide enough for byte offsets inside any data bus up to 1024 bits.
    localparam int unsigned AddrCalcW = 8;

    typedef logic [1:0]           burst_t;
    typedef logic [2:0]           size_t;
    typedef logic [AddrCalcW-1:0] addr_calc_t;

    localparam burst_t BURST_FIXED = 2'b00;
    localparam burst_t BURST_INCR  = 2'b01;
    localparam burst_t BURST_WRAP  = 2'b10;

    typedef enum logic {
        IDLE,
        BUSY
    } dw_state_e;

    function automatic addr_calc_t beat_bytes(input size_t size);
        return addr_calc_t'(1) << size;
    endfunction

    function automatic addr_calc_t aligned_addr(input addr_calc_t addr, input size_t size);
        return addr & ~(beat_bytes(size) - addr_calc_t'(1));
    endfunction

    function automatic addr_calc_t last_byte(input addr_calc_t aligned, input size_t size);
        return aligned + beat_bytes(size) - addr_calc_t'(1);
    endfunction

    function automatic addr_calc_t lane_of(input addr_calc_t byte_addr, input int unsigned lane_shift);
        return byte_addr >> lane_shift;
    endfunction

endpackage

// File: rtl/axi_dw_cmd_fifo.sv
// Command queue between the AW splitter and the W downsizer. Entries become
// visible one cycle after the push; a full queue refuses pushes even when popped.
module axi_dw_cmd_fifo #(
    parameter int unsigned Width = 17,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr, rd_ptr;
    logic [CntW-1:0]  count;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count == CntW'(Depth));
    assign empty_o = (count == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/axi_w_downsizer.sv
// W-channel downsizer: splits each wide write beat into narrow beats following
// the queued burst command, regenerates w_last and flags upstream last errors.
module axi_w_downsizer
    import axi_pkg::*;
#(
    parameter  int unsigned SlvDataWidth = 128,
    parameter  int unsigned MstDataWidth = 32,
    parameter  int unsigned UserWidth    = 1,
    parameter  int unsigned CmdDepth     = 4,
    localparam int unsigned SlvOff       = $clog2(SlvDataWidth / 8),
    localparam int unsigned MstOff       = $clog2(MstDataWidth / 8)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [SlvOff-1:0]         cmd_offset_i,
    input  logic [2:0]                cmd_size_i,
    input  logic [7:0]                cmd_len_i,
    input  logic [1:0]                cmd_burst_i,
    input  logic [SlvDataWidth-1:0]   slv_w_data_i,
    input  logic [SlvDataWidth/8-1:0] slv_w_strb_i,
    input  logic [UserWidth-1:0]      slv_w_user_i,
    input  logic                      slv_w_last_i,
    input  logic                      slv_w_valid_i,
    output logic                      slv_w_ready_o,
    output logic [MstDataWidth-1:0]   mst_w_data_o,
    output logic [MstDataWidth/8-1:0] mst_w_strb_o,
    output logic [UserWidth-1:0]      mst_w_user_o,
    output logic                      mst_w_last_o,
    output logic                      mst_w_valid_o,
    input  logic                      mst_w_ready_i,
    output logic                      last_err_o
);

    localparam int unsigned LaneW    = SlvOff - MstOff;
    localparam int unsigned MstStrbW = MstDataWidth / 8;
    localparam int unsigned CmdW     = SlvOff + 3 + 8 + 2;

    dw_state_e         state_q, state_d;
    logic [SlvOff-1:0] addr_q;
    size_t             size_q;
    burst_t            burst_q;
    logic [7:0]        beats_left_q;
    logic [LaneW-1:0]  lane_q;

    logic              cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic [CmdW-1:0]   cmd_wdata, cmd_rdata;
    logic [SlvOff-1:0] cmd_rd_offset;

    logic [SlvOff-1:0] aligned, next_addr;
    logic [LaneW-1:0]  end_lane, next_lane, load_lane;
    logic              busy, final_lane, last_beat, sub_hs, beat_hs, burst_end;

    assign cmd_ready_o = ~cmd_full & ~rst_i;
    assign cmd_push    = cmd_valid_i & cmd_ready_o;
    assign cmd_wdata   = {cmd_offset_i, cmd_size_i, cmd_len_i, cmd_burst_i};

    axi_dw_cmd_fifo #(
        .Width (CmdW),
        .Depth (CmdDepth)
    ) i_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_push),
        .data_i  (cmd_wdata),
        .full_o  (cmd_full),
        .pop_i   (cmd_pop),
        .data_o  (cmd_rdata),
        .empty_o (cmd_empty)
    );

    assign cmd_rd_offset = cmd_rdata[CmdW-1 -: SlvOff];

    // Lane window of the current wide beat and where the next beat starts.
    assign aligned    = SlvOff'(aligned_addr(AddrCalcW'(addr_q), size_q));
    assign end_lane   = LaneW'(lane_of(last_byte(AddrCalcW'(aligned), size_q), MstOff));
    assign next_addr  = (burst_q == BURST_INCR)
                      ? SlvOff'(AddrCalcW'(aligned) + beat_bytes(size_q)) : addr_q;
    assign next_lane  = LaneW'(lane_of(AddrCalcW'(next_addr), MstOff));
    assign load_lane  = LaneW'(lane_of(AddrCalcW'(cmd_rd_offset), MstOff));

    assign busy       = (state_q == BUSY) & ~rst_i;
    assign final_lane = (lane_q == end_lane);
    assign last_beat  = (beats_left_q == 8'd0);
    assign sub_hs     = busy & slv_w_valid_i & mst_w_ready_i;
    assign beat_hs    = sub_hs & final_lane;
    assign burst_end  = beat_hs & last_beat;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!cmd_empty) state_d = BUSY;
            BUSY:    if (burst_end && cmd_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mst_w_valid_o = busy & slv_w_valid_i;
        slv_w_ready_o = busy & mst_w_ready_i & final_lane;
        last_err_o    = beat_hs & (slv_w_last_i != last_beat);
        cmd_pop       = ~rst_i & ~cmd_empty & ((state_q == IDLE) | burst_end);
    end

    // A pop at the end of a burst overrides the beat update so bursts chain without a bubble.
    always_ff @(posedge clk_i) begin
        if (cmd_pop) begin
            addr_q       <= cmd_rd_offset;
            size_q       <= cmd_rdata[12:10];
            beats_left_q <= cmd_rdata[9:2];
            burst_q      <= cmd_rdata[1:0];
            lane_q       <= load_lane;
        end else if (beat_hs) begin
            addr_q       <= next_addr;
            lane_q       <= next_lane;
            beats_left_q <= beats_left_q - 8'd1;
        end else if (sub_hs) begin
            lane_q       <= lane_q + LaneW'(1);
        end
    end

    assign mst_w_data_o = slv_w_data_i[int'(lane_q) * MstDataWidth +: MstDataWidth];
    assign mst_w_strb_o = slv_w_strb_i[int'(lane_q) * MstStrbW +: MstStrbW];
    assign mst_w_user_o = slv_w_user_i;
    assign mst_w_last_o = last_beat & final_lane;

    assert property (@(posedge clk_i) disable iff (rst_i)
        cmd_push |-> (cmd_burst_i == BURST_FIXED || cmd_burst_i == BURST_INCR)
                     && (cmd_size_i <= 3'(SlvOff)));

endmodule

// File: tb/tb_axi_w_downsizer.sv
// Directed bench for the 128->32 W downsizer: serialisation patterns, stalls,
// back-to-back bursts, command queue full, last-error pulse and mid-burst reset.
module tb_axi_w_downsizer;
    import axi_pkg::*;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         cmd_valid_i, cmd_ready_o;
    logic [3:0]   cmd_offset_i;
    logic [2:0]   cmd_size_i;
    logic [7:0]   cmd_len_i;
    logic [1:0]   cmd_burst_i;
    logic [127:0] slv_w_data_i;
    logic [15:0]  slv_w_strb_i;
    logic [0:0]   slv_w_user_i;
    logic         slv_w_last_i, slv_w_valid_i, slv_w_ready_o;
    logic [31:0]  mst_w_data_o;
    logic [3:0]   mst_w_strb_o;
    logic [0:0]   mst_w_user_o;
    logic         mst_w_last_o, mst_w_valid_o, mst_w_ready_i, last_err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_w_downsizer #(
        .SlvDataWidth (128),
        .MstDataWidth (32),
        .UserWidth    (1),
        .CmdDepth     (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_offset_i  (cmd_offset_i),
        .cmd_size_i    (cmd_size_i),
        .cmd_len_i     (cmd_len_i),
        .cmd_burst_i   (cmd_burst_i),
        .slv_w_data_i  (slv_w_data_i),
        .slv_w_strb_i  (slv_w_strb_i),
        .slv_w_user_i  (slv_w_user_i),
        .slv_w_last_i  (slv_w_last_i),
        .slv_w_valid_i (slv_w_valid_i),
        .slv_w_ready_o (slv_w_ready_o),
        .mst_w_data_o  (mst_w_data_o),
        .mst_w_strb_o  (mst_w_strb_o),
        .mst_w_user_o  (mst_w_user_o),
        .mst_w_last_o  (mst_w_last_o),
        .mst_w_valid_o (mst_w_valid_o),
        .mst_w_ready_i (mst_w_ready_i),
        .last_err_o    (last_err_o)
    );

    // Lane l of slave beat b carries 0x11111111*l + 0x01000000*b.
    function automatic logic [31:0] word(input int b, input int l);
        return 32'(32'h11111111 * l + 32'h01000000 * b);
    endfunction

    function automatic logic [127:0] beat_data(input int b);
        logic [127:0] d;
        for (int l = 0; l < 4; l++) d[l*32 +: 32] = word(b, l);
        return d;
    endfunction

    // Lane nibbles of strobe 16'hF731.
    logic [3:0] nib [4] = '{4'h1, 4'h3, 4'h7, 4'hF};

    // Serialisation scenarios: command fields and expected sub-beats {beat, lane, last, slv_ready}.
    logic [3:0] sc_off  [4] = '{4'd0, 4'd4, 4'd6, 4'd8};
    logic [2:0] sc_size [4] = '{3'd4, 3'd2, 3'd3, 3'd2};
    logic [7:0] sc_len  [4] = '{8'd0, 8'd2, 8'd1, 8'd3};
    logic [1:0] sc_bst  [4] = '{BURST_INCR, BURST_INCR, BURST_INCR, BURST_FIXED};
    int         sc_first[4] = '{0, 4, 7, 10};
    int         sc_n    [4] = '{4, 3, 3, 4};
    logic [5:0] subs   [14] = '{
        6'b00_00_0_0, 6'b00_01_0_0, 6'b00_10_0_0, 6'b00_11_1_1,
        6'b00_01_0_1, 6'b01_10_0_1, 6'b10_11_1_1,
        6'b00_01_0_1, 6'b01_10_0_0, 6'b01_11_1_1,
        6'b00_10_0_1, 6'b01_10_0_1, 6'b10_10_0_1, 6'b11_10_1_1};

    // Stall/back-to-back cycles: {mst_ready, beat, lane, last, slv_ready}.
    logic [6:0] stall_tab [8] = '{
        7'b1_00_00_0_0, 7'b0_00_01_0_0, 7'b1_00_01_0_0, 7'b0_00_10_0_0,
        7'b1_00_10_0_0, 7'b1_00_11_1_1, 7'b1_01_00_0_1, 7'b1_10_01_1_1};

    task automatic push(input logic [3:0] off, input logic [2:0] sz,
                        input logic [7:0] len, input logic [1:0] bst);
        cmd_valid_i  = 1'b1;
        cmd_offset_i = off;
        cmd_size_i   = sz;
        cmd_len_i    = len;
        cmd_burst_i  = bst;
        @(posedge clk); #1;
        cmd_valid_i  = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; cmd_valid_i = 1'b1; slv_w_valid_i = 1'b1; mst_w_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({mst_w_valid_o, slv_w_ready_o, cmd_ready_o, last_err_o} !== 4'b0000) begin
            failures++; $display("FAIL rst_handshakes: got %b want 0000",
                                 {mst_w_valid_o, slv_w_ready_o, cmd_ready_o, last_err_o});
        end
        @(posedge clk); #1;
        rst_i = 1'b0; cmd_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready_o !== 1'b1) begin
            failures++; $display("FAIL post_rst_cmd_ready: got %b want 1", cmd_ready_o);
        end
        checks++; if ({mst_w_valid_o, slv_w_ready_o, last_err_o} !== 3'b000) begin
            failures++; $display("FAIL post_rst_idle: got %b want 000",
                                 {mst_w_valid_o, slv_w_ready_o, last_err_o});
        end
        @(posedge clk); #1;
        slv_w_valid_i = 1'b0;
    endtask

    task automatic test_serialise;
        int b, idx;
        logic adv;
        logic [31:0] exp_d;
        logic [3:0]  exp_s;
        mst_w_ready_i = 1'b1;
        for (int s = 0; s < 4; s++) begin
            b = 0;
            slv_w_data_i  = beat_data(0);
            slv_w_strb_i  = (s == 0) ? 16'hFFFF : 16'hF731;
            slv_w_last_i  = (sc_len[s] == 8'd0);
            slv_w_valid_i = 1'b1;
            push(sc_off[s], sc_size[s], sc_len[s], sc_bst[s]);
            @(negedge clk);
            checks++; if (mst_w_valid_o !== 1'b0) begin
                failures++; $display("FAIL ser%0d_latency: valid got %b want 0", s, mst_w_valid_o);
            end
            @(posedge clk); #1;
            for (int j = 0; j < sc_n[s]; j++) begin
                idx   = sc_first[s] + j;
                exp_d = word(int'(subs[idx][5:4]), int'(subs[idx][3:2]));
                exp_s = (s == 0) ? 4'hF : nib[subs[idx][3:2]];
                @(negedge clk);
                checks++; if (mst_w_valid_o !== 1'b1) begin
                    failures++; $display("FAIL ser%0d_valid[%0d]: got %b want 1", s, j, mst_w_valid_o);
                end
                checks++; if (mst_w_data_o !== exp_d) begin
                    failures++; $display("FAIL ser%0d_data[%0d]: got %h want %h", s, j, mst_w_data_o, exp_d);
                end
                checks++; if (mst_w_strb_o !== exp_s) begin
                    failures++; $display("FAIL ser%0d_strb[%0d]: got %h want %h", s, j, mst_w_strb_o, exp_s);
                end
                checks++; if ({mst_w_last_o, slv_w_ready_o} !== subs[idx][1:0]) begin
                    failures++; $display("FAIL ser%0d_last_rdy[%0d]: got %b want %b", s, j,
                                         {mst_w_last_o, slv_w_ready_o}, subs[idx][1:0]);
                end
                checks++; if (last_err_o !== 1'b0) begin
                    failures++; $display("FAIL ser%0d_last_err[%0d]: got %b want 0", s, j, last_err_o);
                end
                adv = slv_w_ready_o;
                @(posedge clk); #1;
                if (adv) begin
                    b++;
                    slv_w_data_i = beat_data(b);
                    slv_w_last_i = (b == int'(sc_len[s]));
                end
            end
            @(negedge clk);
            checks++; if (mst_w_valid_o !== 1'b0) begin
                failures++; $display("FAIL ser%0d_idle_after: valid got %b want 0", s, mst_w_valid_o);
            end
            @(posedge clk); #1;
        end
        slv_w_valid_i = 1'b0;
    endtask

    task automatic test_back_to_back;
        int b;
        logic adv;
        logic [31:0] exp_d;
        b = 0;
        slv_w_valid_i = 1'b0;
        slv_w_data_i  = beat_data(0);
        slv_w_strb_i  = 16'hF731;
        slv_w_user_i  = 1'b1;
        slv_w_last_i  = 1'b1;
        push(4'd0, 3'd4, 8'd0, BURST_INCR);
        push(4'd0, 3'd2, 8'd1, BURST_INCR);
        slv_w_valid_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            mst_w_ready_i = stall_tab[c][6];
            exp_d = word(int'(stall_tab[c][5:4]), int'(stall_tab[c][3:2]));
            @(negedge clk);
            checks++; if (mst_w_valid_o !== 1'b1) begin
                failures++; $display("FAIL b2b_valid[%0d]: got %b want 1", c, mst_w_valid_o);
            end
            checks++; if (mst_w_data_o !== exp_d) begin
                failures++; $display("FAIL b2b_data[%0d]: got %h want %h", c, mst_w_data_o, exp_d);
            end
            checks++; if (mst_w_strb_o !== nib[stall_tab[c][3:2]]) begin
                failures++; $display("FAIL b2b_strb[%0d]: got %h want %h", c, mst_w_strb_o,
                                     nib[stall_tab[c][3:2]]);
            end
            checks++; if ({mst_w_last_o, slv_w_ready_o} !== stall_tab[c][1:0]) begin
                failures++; $display("FAIL b2b_last_rdy[%0d]: got %b want %b", c,
                                     {mst_w_last_o, slv_w_ready_o}, stall_tab[c][1:0]);
            end
            checks++; if (mst_w_user_o !== 1'b1) begin
                failures++; $display("FAIL b2b_user[%0d]: got %b want 1", c, mst_w_user_o);
            end
            adv = slv_w_ready_o;
            @(posedge clk); #1;
            if (adv) begin
                b++;
                slv_w_data_i = beat_data(b);
                slv_w_last_i = (b == 2);
            end
        end
        @(negedge clk);
        checks++; if (mst_w_valid_o !== 1'b0) begin
            failures++; $display("FAIL b2b_idle_after: valid got %b want 0", mst_w_valid_o);
        end
        @(posedge clk); #1;
        slv_w_valid_i = 1'b0;
        slv_w_user_i  = 1'b0;
    endtask

    task automatic test_fifo_full;
        slv_w_valid_i = 1'b0;
        mst_w_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) push(4'd0, 3'd2, 8'd0, BURST_INCR);
        @(negedge clk);
        checks++; if (cmd_ready_o !== 1'b0) begin
            failures++; $display("FAIL full_cmd_ready: got %b want 0", cmd_ready_o);
        end
        push(4'd4, 3'd2, 8'd0, BURST_INCR);
        @(negedge clk);
        checks++; if (cmd_ready_o !== 1'b0) begin
            failures++; $display("FAIL full_stays_full: got %b want 0", cmd_ready_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        slv_w_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if ({mst_w_valid_o, cmd_ready_o} !== 2'b01) begin
                failures++; $display("FAIL full_flushed[%0d]: valid/cmd_ready got %b want 01", i,
                                     {mst_w_valid_o, cmd_ready_o});
            end
            @(posedge clk); #1;
        end
        slv_w_valid_i = 1'b0;
    endtask

    task automatic test_last_err_and_reset;
        mst_w_ready_i = 1'b1;
        slv_w_strb_i  = 16'hFFFF;
        slv_w_data_i  = beat_data(0);
        slv_w_last_i  = 1'b1;
        slv_w_valid_i = 1'b1;
        push(4'd0, 3'd2, 8'd1, BURST_INCR);
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if ({mst_w_valid_o, last_err_o, mst_w_last_o, slv_w_ready_o} !== 4'b1101) begin
            failures++; $display("FAIL lerr_beat0: valid/err/last/rdy got %b want 1101",
                                 {mst_w_valid_o, last_err_o, mst_w_last_o, slv_w_ready_o});
        end
        @(posedge clk); #1;
        slv_w_data_i = beat_data(1);
        @(negedge clk);
        checks++; if ({mst_w_valid_o, last_err_o, mst_w_last_o, slv_w_ready_o} !== 4'b1011) begin
            failures++; $display("FAIL lerr_beat1: valid/err/last/rdy got %b want 1011",
                                 {mst_w_valid_o, last_err_o, mst_w_last_o, slv_w_ready_o});
        end
        checks++; if (mst_w_data_o !== word(1, 1)) begin
            failures++; $display("FAIL lerr_data1: got %h want %h", mst_w_data_o, word(1, 1));
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if ({mst_w_valid_o, last_err_o} !== 2'b00) begin
            failures++; $display("FAIL lerr_after: valid/err got %b want 00", {mst_w_valid_o, last_err_o});
        end
        @(posedge clk); #1;
        slv_w_data_i = beat_data(2);
        slv_w_last_i = 1'b0;
        push(4'd0, 3'd4, 8'd1, BURST_INCR);
        push(4'd0, 3'd4, 8'd0, BURST_INCR);
        @(negedge clk);
        checks++; if (mst_w_valid_o !== 1'b1 || mst_w_data_o !== word(2, 0)) begin
            failures++; $display("FAIL rstmid_pre: valid %b data %h want 1 %h",
                                 mst_w_valid_o, mst_w_data_o, word(2, 0));
        end
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(negedge clk);
        checks++; if ({mst_w_valid_o, slv_w_ready_o, cmd_ready_o, last_err_o} !== 4'b0000) begin
            failures++; $display("FAIL rstmid_during: got %b want 0000",
                                 {mst_w_valid_o, slv_w_ready_o, cmd_ready_o, last_err_o});
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({mst_w_valid_o, cmd_ready_o} !== 2'b01) begin
                failures++; $display("FAIL rstmid_after[%0d]: valid/cmd_ready got %b want 01", i,
                                     {mst_w_valid_o, cmd_ready_o});
            end
            @(posedge clk); #1;
        end
        slv_w_valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_offset_i = '0; cmd_size_i = '0;
        cmd_len_i = '0; cmd_burst_i = BURST_INCR; slv_w_data_i = '0; slv_w_strb_i = '0;
        slv_w_user_i = '0; slv_w_last_i = 1'b0; slv_w_valid_i = 1'b0; mst_w_ready_i = 1'b0;
        test_reset();
        test_serialise();
        test_back_to_back();
        test_fifo_full();
        test_last_err_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
